// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings and the decoder control bundle layout.
package mips_pkg;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] DM2REG_ALU = 2'b00;
    localparam logic [1:0] DM2REG_DM  = 2'b01;
    localparam logic [1:0] DM2REG_PC4 = 2'b10;

    localparam int CTRL_W = 11;

    typedef struct packed {
        logic       we_reg;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic       branch;
        logic       we_dm;
        logic [1:0] dm2reg;
        logic [1:0] alu_op;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX boundary: decoder/regfile inputs, flush/hold controls, registered EX outputs.
interface id_ex_stage_if #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
);
    logic          id_we_reg;
    logic [1:0]    id_reg_dst;
    logic          id_alu_src;
    logic          id_branch;
    logic          id_we_dm;
    logic [1:0]    id_dm2reg;
    logic [1:0]    id_alu_op;
    logic          id_jump;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] id_sext_imm;
    logic [DW-1:0] id_pc_plus4;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [5:0]    id_funct;
    logic          flush;
    logic          hold_ex;
    logic          stall_id;

    logic          ex_we_reg;
    logic [1:0]    ex_reg_dst;
    logic          ex_alu_src;
    logic          ex_branch;
    logic          ex_we_dm;
    logic [1:0]    ex_dm2reg;
    logic [1:0]    ex_alu_op;
    logic          ex_jump;
    logic [DW-1:0] ex_rd1;
    logic [DW-1:0] ex_rd2;
    logic [DW-1:0] ex_sext_imm;
    logic [DW-1:0] ex_pc_plus4;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [RW-1:0] ex_rd;
    logic [5:0]    ex_funct;
    logic          ex_valid;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_we_reg, id_reg_dst, id_alu_src, id_branch, id_we_dm, id_dm2reg,
               id_alu_op, id_jump, id_rd1, id_rd2, id_sext_imm, id_pc_plus4,
               id_rs, id_rt, id_rd, id_funct, flush, hold_ex,
        input  stall_id, ex_we_reg, ex_reg_dst, ex_alu_src, ex_branch, ex_we_dm,
               ex_dm2reg, ex_alu_op, ex_jump, ex_rd1, ex_rd2, ex_sext_imm,
               ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_funct, ex_valid, bubble_cnt
    );

    modport slave (
        input  id_we_reg, id_reg_dst, id_alu_src, id_branch, id_we_dm, id_dm2reg,
               id_alu_op, id_jump, id_rd1, id_rd2, id_sext_imm, id_pc_plus4,
               id_rs, id_rt, id_rd, id_funct, flush, hold_ex,
        output stall_id, ex_we_reg, ex_reg_dst, ex_alu_src, ex_branch, ex_we_dm,
               ex_dm2reg, ex_alu_op, ex_jump, ex_rd1, ex_rd2, ex_sext_imm,
               ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_funct, ex_valid, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_lu_hazard_detect.sv
// Load-use hazard: a valid load in EX whose destination is a source of the ID instruction.
module lu_hazard_detect
    import mips_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          ex_valid,
    input  logic [1:0]    ex_dm2reg,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_alu_src,
    input  logic          id_we_dm,
    output logic          lu
);
    logic rt_is_source;

    // rt is read by register-register ops and by stores (store data)
    assign rt_is_source = ~id_alu_src | id_we_dm;

    assign lu = ex_valid && (ex_dm2reg == DM2REG_DM) && (ex_rt != '0) &&
                ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_is_source));
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, flush/hold and bubble counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);
    ctrl_t            id_ctrl;
    ctrl_t            ex_ctrl;
    logic [DW-1:0]    ex_rd1, ex_rd2, ex_sext_imm, ex_pc_plus4;
    logic [RW-1:0]    ex_rs, ex_rt, ex_rd;
    logic [5:0]       ex_funct;
    logic             ex_valid;
    logic [CNT_W-1:0] bubble_cnt;
    logic             lu;

    assign id_ctrl = '{we_reg:  bus.id_we_reg,  reg_dst: bus.id_reg_dst,
                       alu_src: bus.id_alu_src, branch:  bus.id_branch,
                       we_dm:   bus.id_we_dm,   dm2reg:  bus.id_dm2reg,
                       alu_op:  bus.id_alu_op,  jump:    bus.id_jump};

    lu_hazard_detect #(.RW(RW)) u_lu (
        .ex_valid   (ex_valid),
        .ex_dm2reg  (ex_ctrl.dm2reg),
        .ex_rt      (ex_rt),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_alu_src (bus.id_alu_src),
        .id_we_dm   (bus.id_we_dm),
        .lu         (lu)
    );

    // Driven only from inputs and EX state, so a flush cannot loop back through squashed state
    assign bus.stall_id = (bus.hold_ex | lu) & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl     <= BUBBLE_CTRL;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_sext_imm <= '0;
            ex_pc_plus4 <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_valid    <= 1'b0;
            bubble_cnt  <= '0;
        end else if (bus.flush || (!bus.hold_ex && lu)) begin
            ex_ctrl     <= BUBBLE_CTRL;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_sext_imm <= '0;
            ex_pc_plus4 <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_valid    <= 1'b0;
            if (!bus.flush && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else if (!bus.hold_ex) begin
            ex_ctrl     <= id_ctrl;
            ex_rd1      <= bus.id_rd1;
            ex_rd2      <= bus.id_rd2;
            ex_sext_imm <= bus.id_sext_imm;
            ex_pc_plus4 <= bus.id_pc_plus4;
            ex_rs       <= bus.id_rs;
            ex_rt       <= bus.id_rt;
            ex_rd       <= bus.id_rd;
            ex_funct    <= bus.id_funct;
            ex_valid    <= 1'b1;
        end
    end

    assign bus.ex_we_reg   = ex_ctrl.we_reg;
    assign bus.ex_reg_dst  = ex_ctrl.reg_dst;
    assign bus.ex_alu_src  = ex_ctrl.alu_src;
    assign bus.ex_branch   = ex_ctrl.branch;
    assign bus.ex_we_dm    = ex_ctrl.we_dm;
    assign bus.ex_dm2reg   = ex_ctrl.dm2reg;
    assign bus.ex_alu_op   = ex_ctrl.alu_op;
    assign bus.ex_jump     = ex_ctrl.jump;
    assign bus.ex_rd1      = ex_rd1;
    assign bus.ex_rd2      = ex_rd2;
    assign bus.ex_sext_imm = ex_sext_imm;
    assign bus.ex_pc_plus4 = ex_pc_plus4;
    assign bus.ex_rs       = ex_rs;
    assign bus.ex_rt       = ex_rt;
    assign bus.ex_rd       = ex_rd;
    assign bus.ex_funct    = ex_funct;
    assign bus.ex_valid    = ex_valid;
    assign bus.bubble_cnt  = bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + randomized bench for id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic          we_reg;
        logic [1:0]    reg_dst;
        logic          alu_src;
        logic          branch;
        logic          we_dm;
        logic [1:0]    dm2reg;
        logic [1:0]    alu_op;
        logic          jump;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [5:0]    funct;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    instr_t cur;
    logic   flush, hold;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) bus ();
    id_ex_stage #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.id_we_reg   = cur.we_reg;
    assign bus.id_reg_dst  = cur.reg_dst;
    assign bus.id_alu_src  = cur.alu_src;
    assign bus.id_branch   = cur.branch;
    assign bus.id_we_dm    = cur.we_dm;
    assign bus.id_dm2reg   = cur.dm2reg;
    assign bus.id_alu_op   = cur.alu_op;
    assign bus.id_jump     = cur.jump;
    assign bus.id_rd1      = cur.rd1;
    assign bus.id_rd2      = cur.rd2;
    assign bus.id_sext_imm = cur.imm;
    assign bus.id_pc_plus4 = cur.pc4;
    assign bus.id_rs       = cur.rs;
    assign bus.id_rt       = cur.rt;
    assign bus.id_rd       = cur.rd;
    assign bus.id_funct    = cur.funct;
    assign bus.flush       = flush;
    assign bus.hold_ex     = hold;

    // Reference model: the instruction sitting in EX, whether it is real, and the bubble tally
    instr_t m_ex;
    logic   m_valid;
    int     m_cnt;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_hazard(instr_t id);
        logic reads_rt;
        reads_rt = !id.alu_src || id.we_dm;
        return m_valid && m_ex.dm2reg == 2'b01 && m_ex.rt != 0 &&
               (id.rs == m_ex.rt || (reads_rt && id.rt == m_ex.rt));
    endfunction

    task automatic model_reset();
        m_ex    = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        check_eq("ex_ctrl", 64'({bus.ex_we_reg, bus.ex_reg_dst, bus.ex_alu_src, bus.ex_branch,
                                 bus.ex_we_dm, bus.ex_dm2reg, bus.ex_alu_op, bus.ex_jump}),
                 64'({m_ex.we_reg, m_ex.reg_dst, m_ex.alu_src, m_ex.branch,
                      m_ex.we_dm, m_ex.dm2reg, m_ex.alu_op, m_ex.jump}));
        check_eq("ex_rd1", 64'(bus.ex_rd1), 64'(m_ex.rd1));
        check_eq("ex_rd2", 64'(bus.ex_rd2), 64'(m_ex.rd2));
        check_eq("ex_imm_pc4", {bus.ex_sext_imm, bus.ex_pc_plus4}, {m_ex.imm, m_ex.pc4});
        check_eq("ex_regs", 64'({bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_funct}),
                 64'({m_ex.rs, m_ex.rt, m_ex.rd, m_ex.funct}));
        check_eq("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        check_eq("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_cnt));
    endtask

    // Inputs must already be set; checks stall before the edge and EX state after it
    task automatic do_cycle();
        logic lu;
        lu = model_hazard(cur);
        #1;
        check_eq("stall_id", 64'(bus.stall_id), 64'((hold || lu) && !flush));
        @(posedge clk);
        if (flush) begin
            m_ex = '0; m_valid = 1'b0;
        end else if (hold) begin
            // EX keeps its instruction
        end else if (lu) begin
            m_ex = '0; m_valid = 1'b0;
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            m_ex = cur; m_valid = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    function automatic instr_t mk_rtype(int rs, int rt, int rd, int a, int b);
        instr_t i = '0;
        i.we_reg = 1; i.reg_dst = 2'b01; i.alu_op = 2'b10; i.funct = 6'h20;
        i.rs = RW'(rs); i.rt = RW'(rt); i.rd = RW'(rd);
        i.rd1 = DW'(a); i.rd2 = DW'(b); i.pc4 = 32'h0040_0010;
        return i;
    endfunction

    function automatic instr_t mk_lw(int rs, int rt);
        instr_t i = '0;
        i.we_reg = 1; i.alu_src = 1; i.dm2reg = 2'b01;
        i.rs = RW'(rs); i.rt = RW'(rt); i.imm = 32'h4; i.pc4 = 32'h0040_0004;
        return i;
    endfunction

    function automatic instr_t mk_addi(int rs, int rt);
        instr_t i = '0;
        i.we_reg = 1; i.alu_src = 1;
        i.rs = RW'(rs); i.rt = RW'(rt); i.imm = 32'hFFFF_FFFC;
        return i;
    endfunction

    function automatic logic [RW-1:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return RW'(8);
            2:       return RW'(9);
            default: return RW'($urandom);
        endcase
    endfunction

    initial begin
        cur = '0; flush = 0; hold = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_outputs();
        check_eq("reset_stall", 64'(bus.stall_id), 64'd0);

        // R-type add captured with one cycle of latency
        cur = mk_rtype(1, 2, 3, 5, 7);
        do_cycle();
        check_eq("add_alu_op", 64'(bus.ex_alu_op), 64'd2);
        check_eq("add_reg_dst", 64'(bus.ex_reg_dst), 64'd1);
        check_eq("add_rd1", 64'(bus.ex_rd1), 64'd5);
        check_eq("add_valid", 64'(bus.ex_valid), 64'd1);

        // LW $8 then ADD using rs=8: one bubble, then ADD enters EX
        cur = mk_lw(4, 8);
        do_cycle();
        cur = mk_rtype(8, 2, 9, 1, 1);
        #1 check_eq("lu_stall", 64'(bus.stall_id), 64'd1);
        do_cycle();
        check_eq("lu_bubble_cnt", 64'(bus.bubble_cnt), 64'd1);
        check_eq("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
        do_cycle();
        check_eq("add_after_bubble", 64'({bus.ex_valid, bus.ex_rs}), 64'({1'b1, 5'd8}));

        // Asynchronous reset mid-run while EX holds a real instruction
        cur = mk_lw(4, 8);
        do_cycle();
        cur = mk_rtype(8, 8, 1, 0, 0);
        #3 rst = 1;
        #1;
        model_reset();
        check_outputs();
        check_eq("reset_mid_stall", 64'(bus.stall_id), 64'd0);
        #1 rst = 0;

        // LW to $0 followed by a $0 consumer: no hazard
        cur = mk_lw(4, 0);
        do_cycle();
        cur = mk_rtype(0, 0, 5, 0, 0);
        #1 check_eq("zero_nostall", 64'(bus.stall_id), 64'd0);
        do_cycle();
        // LW $8 then ADDI writing $8 only: no hazard
        cur = mk_lw(4, 8);
        do_cycle();
        cur = mk_addi(9, 8);
        #1 check_eq("addi_nostall", 64'(bus.stall_id), 64'd0);
        do_cycle();

        // Flush beats hold and a pending load-use
        cur = mk_lw(4, 8);
        do_cycle();
        cur = mk_rtype(8, 2, 3, 0, 0);
        flush = 1; hold = 1;
        #1 check_eq("flush_stall", 64'(bus.stall_id), 64'd0);
        do_cycle();
        check_eq("flush_cnt", 64'(bus.bubble_cnt), 64'd0);
        flush = 0; hold = 0;

        // Hold for three cycles with changing ID inputs
        cur = mk_rtype(1, 2, 3, 11, 22);
        do_cycle();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            cur = mk_rtype(i + 4, 5, 6, i, i);
            do_cycle();
        end
        check_eq("hold_frozen", 64'(bus.ex_rd1), 64'd11);
        hold = 0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cur = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            cur.rs = pick_reg();
            cur.rt = pick_reg();
            cur.dm2reg = 2'($urandom_range(0, 2));
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            do_cycle();
        end
        flush = 0; hold = 0;

        // Saturation: back-to-back self-dependent loads, more than 2^CNT_W hazards
        @(negedge clk);
        rst = 1;
        #1 rst = 0;
        model_reset();
        cur = mk_lw(8, 8);
        for (int n = 0; n < 2 * ((1 << CNT_W) + 3); n++) do_cycle();
        check_eq("cnt_saturated", 64'(bus.bubble_cnt), 64'(CMAX));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
